// File: rtl/bwt_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bwt_search_ctrl
// Brief    : FM-index backward-search controller over a 2-bit BWT; define
//            BWT_SEARCH_ABORT_EN to add the abort input.
// Revision : 1.0
// ============================================================================
module bwt_search_ctrl #(
    parameter int TAGT_LENGTH = 6,
    parameter int REF_LENGTH  = 10,
    parameter int REF_NUM     = 1024,
    parameter int C_A         = 1,
    parameter int C_C         = 257,
    parameter int C_G         = 513,
    parameter int C_T         = 769
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [TAGT_LENGTH:0]   tgt_len,
    output logic                   tgt_rEn,
    output logic [TAGT_LENGTH-1:0] tgt_addr,
    input  logic [1:0]             tgt_base,
    output logic [1:0]             sig,
    output logic                   rEn,
    output logic [REF_LENGTH-1:0]  rAddr0,
    output logic [REF_LENGTH-1:0]  rAddr1,
    input  logic [REF_LENGTH-1:0]  data0,
    input  logic [REF_LENGTH-1:0]  data1,
`ifdef BWT_SEARCH_ABORT_EN
    input  logic                   abort,
`endif
    output logic                   busy,
    output logic                   done,
    output logic                   found,
    output logic [REF_LENGTH-1:0]  sa_lo,
    output logic [REF_LENGTH-1:0]  sa_hi,
    output logic [TAGT_LENGTH:0]   match_len
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        OCC   = 3'd2,
        UPD   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Truncating the C values up front equals a wide add followed by truncation
    localparam logic [REF_LENGTH-1:0]  c_cA     = C_A[REF_LENGTH-1:0];
    localparam logic [REF_LENGTH-1:0]  c_cC     = C_C[REF_LENGTH-1:0];
    localparam logic [REF_LENGTH-1:0]  c_cG     = C_G[REF_LENGTH-1:0];
    localparam logic [REF_LENGTH-1:0]  c_cT     = C_T[REF_LENGTH-1:0];
    localparam logic [REF_LENGTH-1:0]  c_refMax = REF_LENGTH'(REF_NUM - 1);
    localparam logic [REF_LENGTH-1:0]  c_refOne = REF_LENGTH'(1);
    localparam logic [TAGT_LENGTH-1:0] c_idxOne = TAGT_LENGTH'(1);
    localparam logic [TAGT_LENGTH:0]   c_lenOne = (TAGT_LENGTH + 1)'(1);

    state_t                 r_state;
    state_t                 w_nextState;
    logic [REF_LENGTH-1:0]  r_lo;
    logic [REF_LENGTH-1:0]  r_hi;
    logic [TAGT_LENGTH-1:0] r_idx;
    logic [TAGT_LENGTH:0]   r_matchCnt;
    logic                   r_hit;
    logic [REF_LENGTH-1:0]  w_cBase;
    logic [REF_LENGTH-1:0]  w_d0;
    logic                   w_empty;
    logic [REF_LENGTH-1:0]  w_newLo;
    logic [REF_LENGTH-1:0]  w_newHi;
    logic                   w_abort;

`ifdef BWT_SEARCH_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    always_comb begin
        case (sig)
            2'd1:    w_cBase = c_cC;
            2'd2:    w_cBase = c_cG;
            2'd3:    w_cBase = c_cT;
            default: w_cBase = c_cA;
        endcase
    end

    // Occ(c, -1) is zero by definition, so the lo=0 read result is ignored
    assign w_d0    = (r_lo == '0) ? '0 : data0;
    assign w_empty = (data1 <= w_d0);
    assign w_newLo = w_cBase + w_d0;
    assign w_newHi = w_cBase + data1 - c_refOne;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        tgt_rEn     = 1'b0;
        tgt_addr    = '0;
        rEn         = 1'b0;
        rAddr0      = '0;
        rAddr1      = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = (tgt_len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                busy        = 1'b1;
                tgt_rEn     = 1'b1;
                tgt_addr    = r_idx;
                w_nextState = w_abort ? DONE : OCC;
            end
            OCC: begin
                busy        = 1'b1;
                rEn         = 1'b1;
                rAddr0      = (r_lo == '0) ? '0 : (r_lo - c_refOne);
                rAddr1      = r_hi;
                w_nextState = w_abort ? DONE : UPD;
            end
            UPD: begin
                busy = 1'b1;
                if (w_abort || w_empty || (r_idx == '0)) begin
                    w_nextState = DONE;
                end else begin
                    w_nextState = FETCH;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo       <= '0;
            r_hi       <= '0;
            r_idx      <= '0;
            r_matchCnt <= '0;
            r_hit      <= 1'b0;
            sig        <= '0;
            done       <= 1'b0;
            found      <= 1'b0;
            sa_lo      <= '0;
            sa_hi      <= '0;
            match_len  <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_lo       <= '0;
                        r_hi       <= c_refMax;
                        r_matchCnt <= '0;
                        r_hit      <= 1'b1;
                        r_idx      <= tgt_len[TAGT_LENGTH-1:0] - c_idxOne;
                    end
                end
                FETCH: begin
                    if (w_abort) begin
                        r_hit <= 1'b0;
                    end
                end
                OCC: begin
                    sig <= tgt_base;
                    if (w_abort) begin
                        r_hit <= 1'b0;
                    end
                end
                UPD: begin
                    // A miss or abort keeps the last non-empty interval as the result
                    if (w_abort || w_empty) begin
                        r_hit <= 1'b0;
                    end else begin
                        r_lo       <= w_newLo;
                        r_hi       <= w_newHi;
                        r_matchCnt <= r_matchCnt + c_lenOne;
                        if (r_idx != '0) begin
                            r_idx <= r_idx - c_idxOne;
                        end
                    end
                end
                DONE: begin
                    done      <= 1'b1;
                    found     <= r_hit;
                    sa_lo     <= r_lo;
                    sa_hi     <= r_hi;
                    match_len <= r_matchCnt;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bwt_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bwt_search_ctrl
// Brief    : Self-checking bench for bwt_search_ctrl with a BWT/Occ memory model
//            and a queue of expected search results.
// Revision : 1.0
// ============================================================================
module tb_bwt_search_ctrl;

    typedef struct packed {
        logic       fnd;
        logic [9:0] lo;
        logic [9:0] hi;
        logic [6:0] ml;
        logic [7:0] lat;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [6:0] tgt_len;
    logic       tgt_rEn;
    logic [5:0] tgt_addr;
    logic [1:0] tgt_base = 2'd0;
    logic [1:0] sig;
    logic       rEn;
    logic [9:0] rAddr0;
    logic [9:0] rAddr1;
    logic [9:0] data0;
    logic [9:0] data1;
    logic       busy;
    logic       done;
    logic       found;
    logic [9:0] sa_lo;
    logic [9:0] sa_hi;
    logic [6:0] match_len;
`ifdef BWT_SEARCH_ABORT_EN
    logic       abort;
`endif

    logic [2:0] sym    [0:1023];
    logic [9:0] occTab [0:3][0:1023];
    logic [1:0] tgtMem [0:63];
    int         cTab   [0:3];
    logic [9:0] ra0 = 10'd0;
    logic [9:0] ra1 = 10'd0;
    logic [9:0] ovD0 = 10'd0;
    logic [9:0] ovD1 = 10'd0;
    int         rdCnt  = 0;
    int         rdNum  = 0;
    int         eqRead = -1;
    res_t       expQ[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    bwt_search_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .tgt_len   (tgt_len),
        .tgt_rEn   (tgt_rEn),
        .tgt_addr  (tgt_addr),
        .tgt_base  (tgt_base),
        .sig       (sig),
        .rEn       (rEn),
        .rAddr0    (rAddr0),
        .rAddr1    (rAddr1),
        .data0     (data0),
        .data1     (data1),
`ifdef BWT_SEARCH_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .done      (done),
        .found     (found),
        .sa_lo     (sa_lo),
        .sa_hi     (sa_hi),
        .match_len (match_len)
    );

    // Target and Occ memories: one-cycle read latency, Occ indexed by current sig
    always @(posedge clk) begin
        if (rEn) begin
            ra0   <= rAddr0;
            ra1   <= rAddr1;
            rdNum <= rdCnt;
            rdCnt <= rdCnt + 1;
        end
        if (tgt_rEn) tgt_base <= tgtMem[tgt_addr];
    end

    always_comb begin
        data0 = occTab[sig][ra0];
        data1 = occTab[sig][ra1];
        if (rdNum == eqRead) begin
            data0 = ovD0;
            data1 = ovD1;
        end
    end

    task automatic init_ref();
        int         j;
        logic [2:0] t;
        int         cnt [0:3];
        cTab[0] = 1; cTab[1] = 257; cTab[2] = 513; cTab[3] = 769;
        for (int i = 0; i < 1024; i++)
            sym[i] = (i < 256) ? 3'd0 : (i < 512) ? 3'd1 : (i < 768) ? 3'd2 : (i < 1023) ? 3'd3 : 3'd4;
        for (int i = 1023; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            t = sym[i]; sym[i] = sym[j]; sym[j] = t;
        end
        for (int c = 0; c < 4; c++) cnt[c] = 0;
        for (int i = 0; i < 1024; i++) begin
            if (sym[i] < 3'd4) cnt[sym[i][1:0]]++;
            for (int c = 0; c < 4; c++) occTab[c][i] = 10'(cnt[c]);
        end
    endtask

    function automatic res_t model(int len, int eqIdx, int abortAt, logic [9:0] o0, logic [9:0] o1);
        res_t        r;
        logic [9:0]  lo, hi, d0, d1;
        logic [10:0] s;
        logic [1:0]  b;
        r.fnd = 1'b1; r.ml = 7'd0; r.lat = 8'd1;
        lo = 10'd0; hi = 10'd1023;
        for (int k = 0; k < len; k++) begin
            if (k == abortAt) begin
                r.fnd = 1'b0; r.lat = 8'(3 * k + 2);
                break;
            end
            b  = tgtMem[len - 1 - k];
            d0 = (lo == 10'd0) ? 10'd0 : occTab[b][lo - 10'd1];
            d1 = occTab[b][hi];
            if (k == eqIdx) begin
                d0 = (lo == 10'd0) ? 10'd0 : o0;
                d1 = o1;
            end
            r.lat = 8'(3 * (k + 1) + 1);
            if (d1 <= d0) begin
                r.fnd = 1'b0;
                break;
            end
            s  = 11'(cTab[b]) + {1'b0, d0};          lo = s[9:0];
            s  = 11'(cTab[b]) + {1'b0, d1} - 11'd1;  hi = s[9:0];
            r.ml = r.ml + 7'd1;
        end
        r.lo = lo; r.hi = hi;
        return r;
    endfunction

    // Picks, base by base, a symbol whose Occ interval stays non-empty
    task automatic build_match(input int len);
        logic [9:0]  lo, hi, d0, d1;
        logic [10:0] s;
        logic [1:0]  b;
        bit          ok;
        lo = 10'd0; hi = 10'd1023; d0 = 10'd0; d1 = 10'd0;
        for (int k = 0; k < len; k++) begin
            ok = 1'b0;
            b  = 2'($urandom_range(0, 3));
            for (int j = 0; j < 4 && !ok; j++) begin
                d0 = (lo == 10'd0) ? 10'd0 : occTab[b][lo - 10'd1];
                d1 = occTab[b][hi];
                if (d1 > d0) ok = 1'b1;
                else b = b + 2'd1;
            end
            tgtMem[len - 1 - k] = b;
            if (!ok) break;
            s = 11'(cTab[b]) + {1'b0, d0};          lo = s[9:0];
            s = 11'(cTab[b]) + {1'b0, d1} - 11'd1;  hi = s[9:0];
        end
    endtask

    task automatic rand_target();
        for (int i = 0; i < 64; i++) tgtMem[i] = 2'($urandom_range(0, 3));
    endtask

    task automatic launch(input int len, input int eqIdx, input int abortAt,
                          input logic [9:0] o0, input logic [9:0] o1, input bit push);
        @(negedge clk);
        eqRead = (eqIdx < 0) ? -1 : rdCnt + eqIdx;
        ovD0   = o0;
        ovD1   = o1;
        if (push) expQ.push_back(model(len, eqIdx, abortAt, o0, o1));
        tgt_len = 7'(len);
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic await_done(output int lat, output bit tmo);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!done && lat < 400);
        tmo = !done;
    endtask

    task automatic test_reset();
        logic [59:0] outs;
        repeat (3) @(posedge clk);
        #1 outs = {tgt_rEn, tgt_addr, sig, rEn, rAddr0, rAddr1, busy, done, found, sa_lo, sa_hi, match_len};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", outs); end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 outs = {tgt_rEn, tgt_addr, sig, rEn, rAddr0, rAddr1, busy, done, found, sa_lo, sa_hi, match_len};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL idle_after_reset got=%h exp=0", outs); end
    endtask

    task automatic test_single_base();
        res_t got, exp; int lat; bit tmo;
        tgtMem[0] = 2'd0;
        expQ.push_back(res_t'{fnd: 1'b1, lo: 10'd1, hi: 10'd250, ml: 7'd1, lat: 8'd4});
        launch(1, 0, -1, 10'd77, 10'd250, 1'b0);
        await_done(lat, tmo);
        exp = expQ.pop_front();
        got = {found, sa_lo, sa_hi, match_len, 8'(lat)};
        checks++;
        if (tmo || got !== exp) begin errors++; $display("FAIL single_base got=%h exp=%h", got, exp); end
    endtask

    task automatic test_two_base();
        res_t got, exp; int lat; bit tmo;
        logic [19:0] addrs, expAddrs;
        tgtMem[1] = 2'd1;
        tgtMem[0] = 2'd2;
        expAddrs = {10'd256, 10'(257 + int'(occTab[1][1023]) - 1)};
        launch(2, -1, -1, 10'd0, 10'd0, 1'b1);
        await_done(lat, tmo);
        exp = expQ.pop_front();
        got = {found, sa_lo, sa_hi, match_len, 8'(lat)};
        checks++;
        if (tmo || got !== exp || exp.lat !== 8'd7) begin errors++; $display("FAIL two_base got=%h exp=%h", got, exp); end
        addrs = {ra0, ra1};
        checks++;
        if (addrs !== expAddrs) begin errors++; $display("FAIL two_base_occ_addr got=%h exp=%h", addrs, expAddrs); end
    endtask

    task automatic test_early_miss();
        res_t got, exp; int lat; bit tmo;
        build_match(3);
        launch(3, 1, -1, 10'd40, 10'd40, 1'b1);
        await_done(lat, tmo);
        exp = expQ.pop_front();
        got = {found, sa_lo, sa_hi, match_len, 8'(lat)};
        checks++;
        if (tmo || got !== exp) begin errors++; $display("FAIL early_miss got=%h exp=%h", got, exp); end
        checks++;
        if ({found, match_len, 8'(lat)} !== {1'b0, 7'd1, 8'd7}) begin
            errors++; $display("FAIL early_miss_fields got=%h exp=%h", {found, match_len, 8'(lat)}, {1'b0, 7'd1, 8'd7});
        end
    endtask

    task automatic test_zero_len();
        res_t got, exp; int lat; bit tmo;
        launch(0, -1, -1, 10'd0, 10'd0, 1'b1);
        await_done(lat, tmo);
        exp = expQ.pop_front();
        got = {found, sa_lo, sa_hi, match_len, 8'(lat)};
        checks++;
        if (tmo || got !== res_t'{fnd: 1'b1, lo: 10'd0, hi: 10'd1023, ml: 7'd0, lat: 8'd1} || got !== exp) begin
            errors++; $display("FAIL zero_len got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_random();
        res_t got, exp; int lat; bit tmo; int len;
        for (int n = 0; n < 6; n++) begin
            len = int'($urandom_range(1, 12));
            if (n % 2 == 0) build_match(len);
            else rand_target();
            launch(len, -1, -1, 10'd0, 10'd0, 1'b1);
            await_done(lat, tmo);
            exp = expQ.pop_front();
            got = {found, sa_lo, sa_hi, match_len, 8'(lat)};
            checks++;
            if (tmo || got !== exp) begin errors++; $display("FAIL random[%0d] len=%0d got=%h exp=%h", n, len, got, exp); end
        end
    endtask

    task automatic test_back_to_back();
        res_t got, exp, first; int lat; logic [27:0] held;
        build_match(6);
        launch(6, -1, -1, 10'd0, 10'd0, 1'b1);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
            if (lat == 3) begin start = 1'b1; tgt_len = 7'd2; end
            if (lat == 4) start = 1'b0;
        end while (!done && lat < 400);
        first = expQ.pop_front();
        got = {found, sa_lo, sa_hi, match_len, 8'(lat)};
        checks++;
        if (!done || got !== first) begin errors++; $display("FAIL busy_start_ignored got=%h exp=%h", got, first); end
        build_match(5);
        launch(5, -1, -1, 10'd0, 10'd0, 1'b1);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
            if (lat == 5) begin
                held = {found, sa_lo, sa_hi, match_len};
                checks++;
                if (held !== {first.fnd, first.lo, first.hi, first.ml}) begin
                    errors++; $display("FAIL result_hold got=%h exp=%h", held, {first.fnd, first.lo, first.hi, first.ml});
                end
            end
        end while (!done && lat < 400);
        exp = expQ.pop_front();
        got = {found, sa_lo, sa_hi, match_len, 8'(lat)};
        checks++;
        if (!done || got !== exp) begin errors++; $display("FAIL back_to_back got=%h exp=%h", got, exp); end
    endtask

    task automatic test_reset_mid();
        res_t got, exp; int lat; bit tmo; bit seen;
        logic [59:0] outs;
        rand_target();
        launch(64, -1, -1, 10'd0, 10'd0, 1'b0);
        @(posedge clk);
        #2;
        checks++;
        if (rEn !== 1'b1) begin errors++; $display("FAIL reached_occ got=%b exp=1", rEn); end
        rst_n = 1'b0;
        #1 outs = {tgt_rEn, tgt_addr, sig, rEn, rAddr0, rAddr1, busy, done, found, sa_lo, sa_hi, match_len};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL async_reset_outputs got=%h exp=0", outs); end
        seen = 1'b0;
        repeat (3) begin @(posedge clk); #1 if (done) seen = 1'b1; end
        rst_n = 1'b1;
        repeat (8) begin @(posedge clk); #1 if (done || busy) seen = 1'b1; end
        checks++;
        if (seen) begin errors++; $display("FAIL no_done_after_reset got=1 exp=0"); end
        build_match(5);
        launch(5, -1, -1, 10'd0, 10'd0, 1'b1);
        await_done(lat, tmo);
        exp = expQ.pop_front();
        got = {found, sa_lo, sa_hi, match_len, 8'(lat)};
        checks++;
        if (tmo || got !== exp) begin errors++; $display("FAIL restart_after_reset got=%h exp=%h", got, exp); end
    endtask

`ifdef BWT_SEARCH_ABORT_EN
    task automatic test_abort();
        res_t got, exp; int lat;
        build_match(8);
        launch(8, -1, 4, 10'd0, 10'd0, 1'b1);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
            if (lat == 5)  start = 1'b1;
            if (lat == 6)  start = 1'b0;
            if (lat == 12) abort = 1'b1;
            if (lat == 13) abort = 1'b0;
        end while (!done && lat < 400);
        exp = expQ.pop_front();
        got = {found, sa_lo, sa_hi, match_len, 8'(lat)};
        checks++;
        if (!done || got !== exp || match_len !== 7'd4) begin errors++; $display("FAIL abort got=%h exp=%h", got, exp); end
    endtask
`endif

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        tgt_len = 7'd0;
`ifdef BWT_SEARCH_ABORT_EN
        abort   = 1'b0;
`endif
        init_ref();
        rand_target();
        test_reset();
        test_single_base();
        test_two_base();
        test_early_miss();
        test_zero_len();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef BWT_SEARCH_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
